ofmap_streamer: RTL and testbench
=================================

Name: ofmap_streamer

Overview:
Reader/serializer for the conv output. On a start pulse, normally conv_done, it walks the conv_ofmap array in row-major order and emits one pixel per beat on a valid/ready stream. Row and frame markers go with the pixels. It sits between conv and any downstream consumer: the pooling stage, an output FIFO or a bench file writer.

Parameters:
DATA_WIDTH, 8 (cnn_defs DATA_WIDTH), pixel width in bits
OFMAP_SIZE, 126 (cnn_defs CONV_OFMAP_SIZE), ofmap side length; must be >= 2
IDX_W, $clog2(OFMAP_SIZE), row/col counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to stream the frame; tie to conv_done
ofmap  in  [DATA_WIDTH-1:0] x OFMAP_SIZE x OFMAP_SIZE  unpacked frame from conv; must stay stable while busy=1
m_data  out  DATA_WIDTH  current pixel
m_valid  out  1  m_data is valid
m_ready  in  1  consumer accepts the beat this cycle
m_last_row  out  1  current beat is the last column of a row
m_last  out  1  current beat is pixel [OFMAP_SIZE-1][OFMAP_SIZE-1]
busy  out  1  frame in progress, from start accept to final handshake
stream_done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset, synchronous and active-high. On the next edge: state=IDLE, row=col=0, m_data=0, m_valid=0, m_last_row=0, m_last=0, busy=0, stream_done=0.
- Reset overrides every other input in the same cycle. Reset mid-frame abandons the frame; no stream_done is produced.
- State IDLE:
  - start=1 at edge N: load pixel [0][0] into m_data.
  - m_valid=1 and busy=1 from cycle N+1.
  - Go to STREAM. Latency from start to first valid is 1 cycle.
- State STREAM:
  - Handshake = m_valid & m_ready.
  - On a handshake that is not the last beat: advance col. When col=OFMAP_SIZE-1, wrap col to 0 and increment row. Register the next pixel into m_data.
  - m_valid stays 1, so the stream sustains 1 beat/cycle while m_ready=1.
  - If m_valid=1 and m_ready=0: m_data, m_last_row, m_last and the counters hold exactly.
  - Valid never drops mid-frame and does not depend on m_ready.
- Flags are registered with the pixel:
  - m_last_row=1 iff the presented pixel's col=OFMAP_SIZE-1.
  - m_last=1 iff row=col=OFMAP_SIZE-1.
- Final handshake (m_last=1 & m_ready=1) at edge M:
  - Next cycle: m_valid=0, m_last=0, m_last_row=0, busy=0, stream_done=1. Go to DONE.
- State DONE: lasts one cycle. stream_done returns to 0 and the block goes to IDLE.
- Frame length is exactly OFMAP_SIZE^2 beats. With m_ready held at 1, start to stream_done is OFMAP_SIZE^2+1 cycles.
- start is ignored in STREAM and DONE; there is no queued restart. A start is accepted only in IDLE.
- m_data is the unmodified stored value (unsigned DATA_WIDTH, as conv produces). No arithmetic or width conversion.
- Counters never exceed OFMAP_SIZE-1. After the last pixel they are cleared to 0 on entry to DONE.

Decomposition:
- cnn_defs gains OFMAP_PIXELS = CONV_OFMAP_SIZE*CONV_OFMAP_SIZE for benches and downstream depth sizing.
- DATA_WIDTH and CONV_OFMAP_SIZE are reused from cnn_defs.
- The state enum (IDLE, STREAM, DONE) stays local.
- One natural sub-module: raster_counter. It is a parameterised row/col counter with an advance input and outputs row, col, last_col and last_pixel. It is reusable by the pooling stage.

Test Plan:
1. Reset with m_ready=1 and start=1 held during reset → all outputs 0. No beat is produced until start is seen after reset is released.
2. OFMAP_SIZE=4, ofmap[i][j]=4i+j, start at cycle 0, m_ready=1 → m_valid first high at cycle 1 with data 0. Data 0..15 appears on consecutive cycles. m_last_row on data 3, 7, 11, 15; m_last only on 15. stream_done pulse at cycle 17, busy low at cycle 17.
3. Same frame, m_ready=1,0,1,0,... → 16 accepted beats in 0..15 order with no duplicates or skips. m_data and flags are unchanged on every cycle where valid=1 and ready=0.
4. start pulsed again at beats 5 and 15 and during the DONE cycle → ignored; exactly 16 beats and one stream_done. A start one cycle after DONE begins a fresh frame with data 0.
5. Reset asserted after the 6th handshake (data 5 accepted) → next cycle m_valid=0, busy=0, no stream_done. A later start streams 0..15 from the beginning.
6. Default parameters chained to conv (128x128 ifmap, 3x3 kernel, start=conv_done) → exactly 15876 beats. The sequence matches conv_ofmap row-major element for element, and m_last occurs only on beat 15876.

Source files
------------

// File: rtl/ofmap_streamer_pkg.sv
// Shared CNN dimensions for the conv output path.
// OFMAP_PIXELS sizes downstream buffers and bench frame lengths.
package ofmap_streamer_pkg;
    localparam int DATA_WIDTH      = 8;
    localparam int CONV_OFMAP_SIZE = 126;
    localparam int OFMAP_PIXELS    = CONV_OFMAP_SIZE * CONV_OFMAP_SIZE;
endpackage

// File: rtl/ofmap_streamer_raster_counter.sv
// Row-major row/col walker over a SIZE x SIZE frame.
// Advancing past the last pixel wraps back to (0,0).
module raster_counter #(
    parameter int SIZE  = 4,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_col_o,
    output logic             last_pixel_o
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign last_col_o   = (col_q == LAST);
    assign last_pixel_o = last_col_o && (row_q == LAST);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance_i) begin
            if (last_col_o) begin
                col_d = '0;
                row_d = last_pixel_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/ofmap_streamer.sv
// Streams the conv ofmap row-major, one pixel per valid/ready beat,
// with row/frame end markers registered alongside each pixel.
module ofmap_streamer #(
    parameter int DATA_WIDTH = ofmap_streamer_pkg::DATA_WIDTH,
    parameter int OFMAP_SIZE = ofmap_streamer_pkg::CONV_OFMAP_SIZE,
    localparam int IDX_W     = $clog2(OFMAP_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] ofmap [OFMAP_SIZE][OFMAP_SIZE],
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last_row,
    output logic                  m_last,
    output logic                  busy,
    output logic                  stream_done
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_valid_q, m_last_row_q, m_last_q, busy_q, done_q;
    logic [IDX_W-1:0]      row, col;
    logic                  last_col, last_pixel, load;

    // The counter points at the next pixel to fetch, so it runs one beat
    // ahead of m_data and wraps to (0,0) as the final pixel is loaded.
    assign load = ((state_q == IDLE) && start) ||
                  ((state_q == STREAM) && m_ready && !m_last_q);

    raster_counter #(
        .SIZE  (OFMAP_SIZE),
        .IDX_W (IDX_W)
    ) u_raster (
        .clk_i        (clk),
        .reset_i      (reset),
        .advance_i    (load),
        .row_o        (row),
        .col_o        (col),
        .last_col_o   (last_col),
        .last_pixel_o (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_row_q <= 1'b0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (load) begin
                m_data_q     <= ofmap[row][col];
                m_last_row_q <= last_col;
                m_last_q     <= last_pixel;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (m_ready && m_last_q) begin
                        m_valid_q    <= 1'b0;
                        m_last_row_q <= 1'b0;
                        m_last_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last_row  = m_last_row_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    assign stream_done = done_q;
endmodule

// File: tb/tb_ofmap_streamer.sv
// Scoreboard bench: a frame-level model queues expected beats on accepted
// starts; a negedge monitor pops and compares on every handshake.
module tb_ofmap_streamer;
    localparam int N  = 5;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          lr;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset, start, m_ready;
    logic [DW-1:0] ofmap [N][N];
    logic [DW-1:0] m_data;
    logic          m_valid, m_last_row, m_last, busy, stream_done;

    int    tests = 0, fails = 0;
    int    rmode = 0;
    int    hs_cnt = 0;
    beat_t q[$];
    logic  exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic  after_rst = 1'b0, hold_chk = 1'b0;
    beat_t held;

    ofmap_streamer #(.DATA_WIDTH(DW), .OFMAP_SIZE(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofmap       (ofmap),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last_row  (m_last_row),
        .m_last      (m_last),
        .busy        (busy),
        .stream_done (stream_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + frame model: inputs seen here are the ones the next edge samples.
    always @(negedge clk) begin
        beat_t b;
        chk("valid", 32'(m_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("stream_done", 32'(stream_done), 32'(exp_done));
        if (!exp_valid) begin
            chk("last_row_idle", 32'(m_last_row), 32'd0);
            chk("last_idle", 32'(m_last), 32'd0);
        end
        if (after_rst) chk("data_after_reset", 32'(m_data), 32'd0);
        if (hold_chk) begin
            chk("hold_data", 32'(m_data), 32'(held.d));
            chk("hold_last_row", 32'(m_last_row), 32'(held.lr));
            chk("hold_last", 32'(m_last), 32'(held.l));
        end
        after_rst = 1'b0;
        hold_chk  = 1'b0;
        if (reset) begin
            q.delete();
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            after_rst = 1'b1;
        end else if (exp_valid) begin
            if (m_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL underflow: beat accepted with no expected pixel at %0t", $time);
                end else begin
                    b = q.pop_front();
                    hs_cnt++;
                    chk("beat_data", 32'(m_data), 32'(b.d));
                    chk("beat_last_row", 32'(m_last_row), 32'(b.lr));
                    chk("beat_last", 32'(m_last), 32'(b.l));
                    if (b.l) begin
                        exp_valid = 1'b0;
                        exp_busy  = 1'b0;
                        exp_done  = 1'b1;
                    end
                end
            end else begin
                hold_chk = 1'b1;
                held     = '{d: m_data, lr: m_last_row, l: m_last};
            end
        end else if (exp_done) begin
            exp_done = 1'b0;
        end else if (start) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    q.push_back('{d: ofmap[i][j], lr: (j == N-1), l: (i == N-1 && j == N-1)});
            hs_cnt    = 0;
            exp_valid = 1'b1;
            exp_busy  = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic fill(input bit seq);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                ofmap[i][j] = seq ? DW'(i * N + j) : DW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cyc();
            if (stream_done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no stream_done within %0d cycles", budget);
        end
    endtask

    task automatic wait_hs(input int n, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cyc();
            if (hs_cnt >= n) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL hs_timeout: fewer than %0d handshakes within %0d cycles", n, budget);
        end
    endtask

    task automatic run_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(8 * N * N);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; m_ready = 1'b1;
        fill(1'b1);
        repeat (3) cyc();
        reset = 1'b0; start = 1'b0;
        repeat (3) cyc();

        // Full-rate frame, then ready toggling every cycle.
        rmode = 0; run_frame(); cyc();
        rmode = 1; run_frame(); cyc();

        // Starts during STREAM and DONE are ignored; a start right after DONE restarts.
        rmode = 0;
        start = 1'b1; cyc(); start = 1'b0;
        wait_hs(5, 4 * N * N);
        start = 1'b1; cyc(); start = 1'b0;
        wait_hs(N * N - 3, 4 * N * N);
        start = 1'b1; cyc(); start = 1'b0;
        wait_done(4 * N * N);
        start = 1'b1; cyc();
        cyc();
        start = 1'b0;
        wait_done(4 * N * N);
        cyc();

        // Reset mid-frame after six accepted beats, then a clean frame.
        start = 1'b1; cyc(); start = 1'b0;
        wait_hs(6, 4 * N * N);
        reset = 1'b1; cyc(); reset = 1'b0;
        repeat (2) cyc();
        run_frame(); cyc();

        // Random frames with random backpressure.
        rmode = 2;
        for (int f = 0; f < 8; f++) begin
            fill(1'b0);
            repeat ($urandom_range(0, 3)) cyc();
            run_frame();
            cyc();
        end

        rmode = 0;
        repeat (3) cyc();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
